// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding and baud timing helpers
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit; the receiver needs at least 4 so the half-bit offset is meaningful.
    function automatic int cpb(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

    function automatic int half_cpb(input int clk_freq, input int baudrate);
        return cpb(clk_freq, baudrate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer with falling-edge detect for the serial line
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (all flops preset to 1 = idle line)
//   line_i  in   raw serial input, asynchronous to clk
//   sync_o  out  synchronized line value
//   fall_o  out  high for one cycle when the synchronized line goes 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Preset to 1 so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop
//
// Optional feature macro: UART_RX_FRAME_ERR_EN (adds the frame_err strobe port).
//
// Ports:
//   clk           in   clock, all logic on posedge
//   rst_n         in   asynchronous active-low reset
//   line          in   serial input, idle high, asynchronous to clk
//   receive_data  out  last correctly framed word, held until the next good frame
//   ready         out  1-cycle strobe marking a new word on receive_data
//   frame_err     out  1-cycle strobe when the stop bit samples low (macro builds only)
import uart_pkg::*;

module uart_receiver #(
    parameter int CLK_FREQ   = 38400,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] receive_data,
    output logic                  ready
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int CPB   = cpb(CLK_FREQ, BAUDRATE);
    localparam int HALF  = half_cpb(CLK_FREQ, BAUDRATE);
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic line_sync;
    logic line_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (line),
        .sync_o (line_sync),
        .fall_o (line_fall)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  ready_q, ready_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic                  ferr_q,  ferr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Only an edge arms the receiver, so a held-low break line stays quiet.
                if (line_fall) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!line_sync) begin
                        state_d = DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    // Shifting in from the top leaves the first (LSB) bit at bit 0.
                    shift_d = {line_sync, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Leaving at mid stop bit gives half a bit of slack for a zero-gap next start.
                    state_d = IDLE;
                    if (line_sync) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_d = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign receive_data = data_q;
    assign ready        = ready_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err    = ferr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver with a frame-level reference model
module tb_uart_receiver;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       line  = 1'b1;
    logic [7:0] receive_data;
    logic       ready;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    uart_receiver #(
        .CLK_FREQ   (38400),
        .BAUDRATE   (9600),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line         (line),
        .receive_data (receive_data),
        .ready        (ready)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    exp_t       expq[$];
    exp_t       cur;
    logic [7:0] rx_log[$];
    logic [7:0] model_data = 8'h00;
    logic [7:0] hello[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int         checks     = 0;
    int         errors     = 0;
    int         ready_cnt  = 0;
    int         ferr_cnt   = 0;
    logic       prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: each frame sent with a good stop bit yields one strobe carrying that byte,
    // 40..42 clocks after its start edge; receive_data holds the last such byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            prev_ready = 1'b0;
        end else begin
            if (ready) begin
                ready_cnt++;
                check("ready_not_consecutive", {31'd0, prev_ready}, 32'd0);
                if (expq.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    cur        = expq.pop_front();
                    model_data = cur.b;
                    check("ready_latency", cyc - cur.t, ((cyc - cur.t) >= 40 && (cyc - cur.t) <= 42) ?
                          cyc - cur.t : 41);
                end
                rx_log.push_back(receive_data);
            end
            check("receive_data", {24'd0, receive_data}, {24'd0, model_data});
            prev_ready = ready;
`ifdef UART_RX_FRAME_ERR_EN
            if (frame_err) ferr_cnt++;
`endif
        end
    end

    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        int   t0;
        t0 = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (stop) begin
            e.b = b;
            e.t = t0;
            expq.push_back(e);
        end
        hold(stop, CPB);
    endtask

    initial begin
        logic [7:0] b5a;
        b5a = 8'h5A;

        rst_n = 1'b0;
        line  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, receive_data}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif
        rst_n = 1'b1;
        hold(1'b1, 10);

        // 1. single frame
        send_frame(8'h48, 1'b1);
        hold(1'b1, 8);
        check("t1_data", {24'd0, receive_data}, 32'h48);
        check("t1_count", ready_cnt, 1);

        // 2. back-to-back, zero idle gap
        send_frame(8'h65, 1'b1);
        send_frame(8'h6C, 1'b1);
        hold(1'b1, 8);
        check("t2_data", {24'd0, receive_data}, 32'h6C);
        check("t2_count", ready_cnt, 3);

        // 3. one-cycle glitch
        hold(1'b0, 1);
        hold(1'b1, 20);
        check("t3_data", {24'd0, receive_data}, 32'h6C);
        check("t3_count", ready_cnt, 3);

        // 4. good frame then bad stop bit
        send_frame(8'h31, 1'b1);
        send_frame(8'hA5, 1'b0);
        hold(1'b1, 8);
        check("t4_data", {24'd0, receive_data}, 32'h31);
        check("t4_count", ready_cnt, 4);
`ifdef UART_RX_FRAME_ERR_EN
        check("t4_frame_err", ferr_cnt, 1);
`endif

        // 5. reset during bit 3 of 0x5A
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(b5a[i], CPB);
        line = b5a[3];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_reset_data", {24'd0, receive_data}, 32'd0);
        check("t5_reset_ready", {31'd0, ready}, 32'd0);
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 10);
        send_frame(8'h33, 1'b1);
        hold(1'b1, 8);
        check("t5_data", {24'd0, receive_data}, 32'h33);
        check("t5_count", ready_cnt, 5);

        // Break: long low line gives no strobe, then a clean frame
        hold(1'b0, 100);
        hold(1'b1, 10);
        check("brk_count", ready_cnt, 5);
        check("brk_data", {24'd0, receive_data}, 32'h33);
`ifdef UART_RX_FRAME_ERR_EN
        check("brk_frame_err", ferr_cnt, 2);
`endif
        send_frame(8'h0F, 1'b1);
        hold(1'b1, 8);
        check("post_brk_data", {24'd0, receive_data}, 32'h0F);
        check("post_brk_count", ready_cnt, 6);

        // 6. "Hello" stream, back to back
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
        hold(1'b1, 8);
        check("hello_count", ready_cnt, 11);
        if (rx_log.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check("hello_byte", {24'd0, rx_log[rx_log.size() - 5 + i]}, {24'd0, hello[i]});
        end else begin
            check("hello_log_size", rx_log.size(), 5);
        end
        check("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
